// File: rtl/sig_dump_ctrl.sv
// End-of-simulation controller: finishes on the core's status word (mode 0)
// or streams the compliance signature region out of RAM word by word (mode 1).
module sig_dump_ctrl #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mode_i,
   input  logic [1:0]  sim_result_i,
   input  logic [31:0] end_flag_i,
   input  logic [31:0] begin_sig_i,
   input  logic [31:0] end_sig_i,
   output logic        ram_req_o,
   output logic [31:0] ram_addr_o,
   input  logic        ram_gnt_i,
   input  logic        ram_rvalid_i,
   input  logic [31:0] ram_rdata_i,
   output logic        sig_valid_o,
   output logic [31:0] sig_data_o,
   input  logic        sig_ready_i,
   output logic        done_o,
   output logic        pass_o,
   output logic        fail_o,
   output logic        timeout_o
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DONE} state_e;

   state_e      state_q, state_d;
   logic        status_end_q, status_end_d;
   logic        flag_set_q, flag_set_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] end_addr_q, end_addr_d;
   logic [31:0] wdog_q, wdog_d;
   logic [31:0] sig_data_q, sig_data_d;
   logic        ram_req_q, ram_req_d;
   logic        sig_valid_q, sig_valid_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        fail_q, fail_d;
   logic        timeout_q, timeout_d;

   logic        trig;
   logic        expire;
   logic [31:0] begin_al;
   logic [31:0] end_al;
   logic [31:0] addr_next;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block can infer a latch.
      state_d      = state_q;
      addr_d       = addr_q;
      end_addr_d   = end_addr_q;
      wdog_d       = wdog_q;
      sig_data_d   = sig_data_q;
      ram_req_d    = ram_req_q;
      sig_valid_d  = sig_valid_q;
      done_d       = done_q;
      pass_d       = pass_q;
      fail_d       = fail_q;
      timeout_d    = timeout_q;

      status_end_d = sim_result_i[0];
      flag_set_d   = (end_flag_i == 32'd1);
      trig         = mode_i ? (flag_set_d & ~flag_set_q) : (status_end_d & ~status_end_q);
      begin_al     = begin_sig_i & ~32'd3;
      end_al       = end_sig_i & ~32'd3;
      addr_next    = addr_q + 32'd4;

      // The counter saturates at the limit so a trigger that beat the expiry is not overridden later.
      expire = (TIMEOUT_CYCLES != 32'd0) && (state_q != DONE) &&
               (wdog_q == TIMEOUT_CYCLES - 32'd1);
      if ((state_q != DONE) && (wdog_q != TIMEOUT_CYCLES)) begin
         wdog_d = wdog_q + 32'd1;
      end

      if (expire && !((state_q == IDLE) && trig)) begin
         state_d     = DONE;
         done_d      = 1'b1;
         timeout_d   = 1'b1;
         fail_d      = 1'b1;
         pass_d      = 1'b0;
         ram_req_d   = 1'b0;
         sig_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (trig) begin
                  if (!mode_i) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     pass_d  = sim_result_i[1];
                     fail_d  = ~sim_result_i[1];
                  end else begin
                     addr_d     = begin_al;
                     end_addr_d = end_al;
                     if (begin_al < end_al) begin
                        state_d   = REQ;
                        ram_req_d = 1'b1;
                     end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                     end
                  end
               end
            end
            REQ: begin
               if (ram_gnt_i) begin
                  state_d   = WAIT;
                  ram_req_d = 1'b0;
               end
            end
            // Only reached after the grant edge, so an rvalid alongside the grant is never seen.
            WAIT: begin
               if (ram_rvalid_i) begin
                  state_d     = OUT;
                  sig_data_d  = ram_rdata_i;
                  sig_valid_d = 1'b1;
               end
            end
            OUT: begin
               if (sig_ready_i) begin
                  sig_valid_d = 1'b0;
                  addr_d      = addr_next;
                  if (addr_next == 32'd0) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     fail_d  = 1'b1;
                  end else if (addr_next < end_addr_q) begin
                     state_d   = REQ;
                     ram_req_d = 1'b1;
                  end else begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     pass_d  = 1'b1;
                  end
               end
            end
            DONE: begin
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         status_end_q <= 1'b0;
         flag_set_q   <= 1'b0;
         addr_q       <= 32'd0;
         end_addr_q   <= 32'd0;
         wdog_q       <= 32'd0;
         sig_data_q   <= 32'd0;
         ram_req_q    <= 1'b0;
         sig_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         status_end_q <= status_end_d;
         flag_set_q   <= flag_set_d;
         addr_q       <= addr_d;
         end_addr_q   <= end_addr_d;
         wdog_q       <= wdog_d;
         sig_data_q   <= sig_data_d;
         ram_req_q    <= ram_req_d;
         sig_valid_q  <= sig_valid_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         timeout_q    <= timeout_d;
      end
   end

   assign ram_req_o   = ram_req_q;
   assign ram_addr_o  = addr_q;
   assign sig_valid_o = sig_valid_q;
   assign sig_data_o  = sig_data_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign fail_o      = fail_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Bench for sig_dump_ctrl: a RAM responder and signature consumer scoreboard
// run beside directed scenarios; u_wd carries a short watchdog limit.
module tb_sig_dump_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        mode_i;
   logic [1:0]  sim_result_i;
   logic [31:0] end_flag_i, begin_sig_i, end_sig_i;
   logic        ram_gnt_i, ram_rvalid_i, sig_ready_i;
   logic [31:0] ram_rdata_i;

   logic        ram_req_o, sig_valid_o, done_o, pass_o, fail_o, timeout_o;
   logic [31:0] ram_addr_o, sig_data_o;
   logic        wd_ram_req, wd_sig_valid, wd_done, wd_pass, wd_fail, wd_timeout;
   logic [31:0] wd_ram_addr, wd_sig_data;

   sig_dump_ctrl u_main (
      .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .sim_result_i(sim_result_i),
      .end_flag_i(end_flag_i), .begin_sig_i(begin_sig_i), .end_sig_i(end_sig_i),
      .ram_req_o(ram_req_o), .ram_addr_o(ram_addr_o), .ram_gnt_i(ram_gnt_i),
      .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
      .sig_valid_o(sig_valid_o), .sig_data_o(sig_data_o), .sig_ready_i(sig_ready_i),
      .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o)
   );

   sig_dump_ctrl #(.TIMEOUT_CYCLES(32'd50)) u_wd (
      .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .sim_result_i(sim_result_i),
      .end_flag_i(end_flag_i), .begin_sig_i(begin_sig_i), .end_sig_i(end_sig_i),
      .ram_req_o(wd_ram_req), .ram_addr_o(wd_ram_addr), .ram_gnt_i(ram_gnt_i),
      .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
      .sig_valid_o(wd_sig_valid), .sig_data_o(wd_sig_data), .sig_ready_i(sig_ready_i),
      .done_o(wd_done), .pass_o(wd_pass), .fail_o(wd_fail), .timeout_o(wd_timeout)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // RAM contents as the bench's memory model sees them.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   bit          req_seen, pend_rv, rv_last, in_word, hold_all;
   logic [31:0] pend_data, hold_data;
   int          words, reqs, stall_word, stall_left;

   // RAM responder (grant one cycle late, garbage rvalid with the grant, real
   // data the cycle after) and signature consumer, both acting on negedges.
   initial begin
      ram_gnt_i = 1'b0; ram_rvalid_i = 1'b0; ram_rdata_i = '0; sig_ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            req_seen = 0; pend_rv = 0; rv_last = 0; in_word = 0;
            ram_gnt_i = 1'b0; ram_rvalid_i = 1'b0; sig_ready_i = 1'b0;
         end else begin
            if (rv_last) check("valid_latency", sig_valid_o, 1);
            rv_last = 0;
            if (ram_req_o) reqs++;

            ram_gnt_i = 1'b0; ram_rvalid_i = 1'b0; ram_rdata_i = '0;
            if (pend_rv) begin
               ram_rvalid_i = 1'b1; ram_rdata_i = pend_data; pend_rv = 0; rv_last = 1;
            end else if (ram_req_o) begin
               if (!req_seen) begin
                  req_seen = 1;
               end else begin
                  req_seen = 0;
                  ram_gnt_i = 1'b1; ram_rvalid_i = 1'b1; ram_rdata_i = 32'hDEAD_BEEF;
                  pend_data = mem_word(ram_addr_o); pend_rv = 1;
                  if (exp_addr_q.size() == 0) check("ram_extra_req", ram_req_o, 0);
                  else check("ram_addr", ram_addr_o, exp_addr_q.pop_front());
               end
            end

            sig_ready_i = 1'b0;
            if (sig_valid_o && !hold_all) begin
               if (!in_word) begin
                  in_word = 1; hold_data = sig_data_o;
               end else begin
                  check("data_hold", sig_data_o, hold_data);
               end
               if (words == stall_word && stall_left > 0) begin
                  stall_left--;
               end else begin
                  sig_ready_i = 1'b1; in_word = 0; words++;
                  if (exp_data_q.size() == 0) check("sig_extra_word", sig_valid_o, 0);
                  else check("sig_data", sig_data_o, exp_data_q.pop_front());
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst_ni = 1'b0;
      mode_i = 1'b0; sim_result_i = 2'b00; end_flag_i = '0; begin_sig_i = '0; end_sig_i = '0;
      hold_all = 0; stall_word = -1; stall_left = 0;
      exp_addr_q.delete(); exp_data_q.delete();
      repeat (2) @(negedge clk_i);
      words = 0; reqs = 0;
      rst_ni = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req"},     ram_req_o,   0);
      check({tag, "_addr"},    ram_addr_o,  0);
      check({tag, "_valid"},   sig_valid_o, 0);
      check({tag, "_data"},    sig_data_o,  0);
      check({tag, "_done"},    done_o,      0);
      check({tag, "_pass"},    pass_o,      0);
      check({tag, "_fail"},    fail_o,      0);
      check({tag, "_timeout"}, timeout_o,   0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!done_o && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_done"}, done_o, 1);
   endtask

   task automatic push_words(input logic [31:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(b + 32'(4 * i));
         exp_data_q.push_back(mem_word(b + 32'(4 * i)));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got expired, expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      // Reset state
      do_reset();
      rst_ni = 1'b0;
      @(negedge clk_i);
      check_zero("reset");

      // Mode 0 pass: done one cycle after the status edge, no RAM traffic
      do_reset();
      @(negedge clk_i);
      check("t1_idle_done", done_o, 0);
      sim_result_i = 2'b11;
      @(negedge clk_i);
      check("t1_done", done_o, 1);
      check("t1_pass", pass_o, 1);
      check("t1_fail", fail_o, 0);
      repeat (3) @(negedge clk_i);
      check("t1_reqs", reqs, 0);

      // Mode 0 fail, then DONE stays absorbing through a new edge
      do_reset();
      @(negedge clk_i);
      sim_result_i = 2'b01;
      @(negedge clk_i);
      check("t2_done", done_o, 1);
      check("t2_fail", fail_o, 1);
      check("t2_pass", pass_o, 0);
      sim_result_i = 2'b00;
      @(negedge clk_i);
      sim_result_i = 2'b11;
      repeat (2) @(negedge clk_i);
      check("t2_absorb_pass", pass_o, 0);
      check("t2_absorb_fail", fail_o, 1);

      // Mode 1 dump of three words with a 3-cycle stall on the second word
      do_reset();
      mode_i = 1'b1; begin_sig_i = 32'h100; end_sig_i = 32'h10C;
      push_words(32'h100, 3);
      stall_word = 1; stall_left = 3;
      @(negedge clk_i);
      end_flag_i = 32'd1;
      @(negedge clk_i);
      check("t3_req_latency", ram_req_o, 1);
      check("t3_first_addr", ram_addr_o, 32'h100);
      mode_i = 1'b0;
      wait_done("t3", 100);
      check("t3_pass", pass_o, 1);
      check("t3_fail", fail_o, 0);
      check("t3_words", words, 3);
      check("t3_req_cycles", reqs, 6);
      check("t3_addr_left", exp_addr_q.size(), 0);
      check("t3_data_left", exp_data_q.size(), 0);

      // Mode 1 empty region
      do_reset();
      mode_i = 1'b1; begin_sig_i = 32'h200; end_sig_i = 32'h200;
      @(negedge clk_i);
      end_flag_i = 32'd1;
      @(negedge clk_i);
      check("t4_done", done_o, 1);
      check("t4_pass", pass_o, 1);
      check("t4_req", ram_req_o, 0);
      repeat (3) @(negedge clk_i);
      check("t4_words", words, 0);
      check("t4_reqs", reqs, 0);

      // Watchdog expiry at cycle 50
      do_reset();
      repeat (49) @(negedge clk_i);
      check("t5_pre_timeout", wd_timeout, 0);
      check("t5_pre_done", wd_done, 0);
      @(negedge clk_i);
      check("t5_timeout", wd_timeout, 1);
      check("t5_fail", wd_fail, 1);
      check("t5_done", wd_done, 1);
      check("t5_pass", wd_pass, 0);
      check("t5_req", wd_ram_req, 0);
      check("t5_valid", wd_sig_valid, 0);

      // Trigger in the expiry cycle wins
      do_reset();
      repeat (49) @(negedge clk_i);
      sim_result_i = 2'b11;
      @(negedge clk_i);
      check("t5b_done", wd_done, 1);
      check("t5b_pass", wd_pass, 1);
      check("t5b_fail", wd_fail, 0);
      check("t5b_timeout", wd_timeout, 0);

      // Reset pulsed while a word sits in OUT, then a fresh dump
      do_reset();
      mode_i = 1'b1; begin_sig_i = 32'h300; end_sig_i = 32'h308;
      push_words(32'h300, 2);
      hold_all = 1;
      @(negedge clk_i);
      end_flag_i = 32'd1;
      for (int n = 0; n < 20 && !sig_valid_o; n++) @(negedge clk_i);
      check("t6_in_out", sig_valid_o, 1);
      rst_ni = 1'b0;
      #1;
      check_zero("t6_abort");
      repeat (3) begin
         @(negedge clk_i);
         check("t6_no_req", ram_req_o, 0);
      end
      do_reset();
      mode_i = 1'b1; begin_sig_i = 32'h300; end_sig_i = 32'h308;
      push_words(32'h300, 2);
      @(negedge clk_i);
      end_flag_i = 32'd1;
      wait_done("t6", 100);
      check("t6_pass", pass_o, 1);
      check("t6_words", words, 2);
      check("t6_data_left", exp_data_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
